// File: rtl/vc_buffer_scheduler.sv
// vc_buffer_scheduler
//
// Per-input-port controller for the virtual-channel flit buffers of a router.
// Steers arriving flits into one of NUM_VC external fifo instances, tracks
// downstream credits per VC, picks one eligible VC per cycle by round-robin,
// pops that VC toward the switch and returns one upstream credit per flit
// drained.
//
// Parameters
//   NUM_VC      number of virtual channels / fifo instances (>= 2)
//   FIFO_DEPTH  depth of each VC fifo (upstream credit pool per VC)
//   CREDIT_MAX  downstream buffer depth per VC; reset value of each counter
//
// Ports
//   clk               clock, all state on rising edge
//   reset             asynchronous active-low reset
//   in_valid/in_vc    flit arriving from the link and its target VC
//   fifo_empty/full   per-VC status flags from the fifos
//   fifo_push         one-hot push to the VC fifos (combinational)
//   fifo_pop          one-hot pop to the VC fifos (combinational)
//   out_ready         switch can accept a flit this cycle
//   out_valid/out_vc  granted VC this cycle (combinational, out_vc=0 if idle)
//   credit_in_*       one credit returned from downstream
//   credit_out_*      one credit returned upstream (registered)
//   overflow_err      sticky: flit for a full VC or an out-of-range VC
//   credit_err        sticky: credit overflow or out-of-range credit VC

module vc_buffer_scheduler #(
    parameter int NUM_VC     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CREDIT_MAX = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [$clog2(NUM_VC)-1:0] in_vc,
    input  logic [NUM_VC-1:0]         fifo_empty,
    input  logic [NUM_VC-1:0]         fifo_full,
    output logic [NUM_VC-1:0]         fifo_push,
    output logic [NUM_VC-1:0]         fifo_pop,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [$clog2(NUM_VC)-1:0] out_vc,
    input  logic                      credit_in_valid,
    input  logic [$clog2(NUM_VC)-1:0] credit_in_vc,
    output logic                      credit_out_valid,
    output logic [$clog2(NUM_VC)-1:0] credit_out_vc,
    output logic                      overflow_err,
    output logic                      credit_err
);

    localparam int VCW = $clog2(NUM_VC);
    localparam int CW  = $clog2(CREDIT_MAX + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_MAX);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_VC < 2) begin : g_bad_num_vc
        $error("vc_buffer_scheduler: NUM_VC must be at least 2");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_fifo_depth
        $error("vc_buffer_scheduler: FIFO_DEPTH must be at least 1");
    end
    if (CREDIT_MAX < 1) begin : g_bad_credit_max
        $error("vc_buffer_scheduler: CREDIT_MAX must be at least 1");
    end

    // State
    logic [VCW-1:0] rr_ptr;
    logic [CW-1:0]  credit [NUM_VC];

    // Decoded indices; an index that matches no VC decodes to all-zero,
    // which is how out-of-range VCs are detected without a compare that
    // would be constant for power-of-two NUM_VC.
    logic [NUM_VC-1:0] in_dec;
    logic [NUM_VC-1:0] cin_dec;
    logic              in_accept;
    logic              cin_in_range;

    logic [NUM_VC-1:0] credit_nz;
    logic [NUM_VC-1:0] credit_at_max;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] grant_oh;
    logic [NUM_VC-1:0] credit_inc;
    logic              grant_found;
    logic [VCW-1:0]    grant_vc;
    logic [VCW-1:0]    rr_next;
    logic              commit;
    logic              credit_err_set;

    // ------------------------------------------------------------------
    // Index decode and push steering
    // ------------------------------------------------------------------
    always_comb begin
        in_dec  = '0;
        cin_dec = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            in_dec[v]  = (in_vc == VCW'(v));
            cin_dec[v] = (credit_in_vc == VCW'(v));
        end
    end

    assign in_accept    = in_valid && |(in_dec & ~fifo_full);
    assign cin_in_range = |cin_dec;
    assign fifo_push    = in_accept ? in_dec : '0;

    // ------------------------------------------------------------------
    // Eligibility: a fifo ignores pop in a cycle where it is pushed, so a
    // VC receiving a flit this cycle cannot be granted. Credits come from
    // the registered count only.
    // ------------------------------------------------------------------
    always_comb begin
        credit_nz     = '0;
        credit_at_max = '0;
        eligible      = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            credit_nz[v]     = (credit[v] != '0);
            credit_at_max[v] = (credit[v] == CREDIT_FULL);
            eligible[v]      = !fifo_empty[v] && credit_nz[v] && !fifo_push[v];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_ptr, wrapping modulo NUM_VC.
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_vc    = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_VC) begin
                cand = cand - NUM_VC;
            end
            if (!grant_found && eligible[cand[VCW-1:0]]) begin
                grant_found = 1'b1;
                grant_vc    = cand[VCW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            grant_oh[v] = (grant_vc == VCW'(v));
        end
    end

    assign out_valid = grant_found;
    assign out_vc    = grant_found ? grant_vc : '0;
    assign commit    = grant_found && out_ready;
    assign fifo_pop  = commit ? grant_oh : '0;
    assign rr_next   = (grant_vc == VCW'(NUM_VC - 1)) ? '0 : grant_vc + 1'b1;

    // ------------------------------------------------------------------
    // Credit bookkeeping. A commit and a returned credit on the same VC
    // cancel out; a lone return saturates at CREDIT_MAX and flags an error.
    // ------------------------------------------------------------------
    assign credit_inc     = credit_in_valid ? cin_dec : '0;
    assign credit_err_set = credit_in_valid &&
                            (!cin_in_range || |(credit_inc & ~fifo_pop & credit_at_max));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                credit[v] <= CREDIT_FULL;
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (fifo_pop[v] && !credit_inc[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end else if (credit_inc[v] && !fifo_pop[v] && !credit_at_max[v]) begin
                    credit[v] <= credit[v] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter pointer, upstream credit return and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (commit) begin
            rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
        end else begin
            credit_out_valid <= commit;
            if (commit) begin
                credit_out_vc <= grant_vc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            if (in_valid && !in_accept) begin
                overflow_err <= 1'b1;
            end
            if (credit_err_set) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_buffer_scheduler.sv
// Testbench for vc_buffer_scheduler: a reference model (fifo occupancies,
// credit counts, round-robin pointer) computes each cycle's expected outputs
// and queues them; a monitor at the falling edge pops and compares.

module tb_vc_buffer_scheduler;

    localparam int NUM_VC     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CREDIT_MAX = 8;
    localparam int VCW        = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [VCW-1:0]    in_vc;
    logic [NUM_VC-1:0] fifo_empty;
    logic [NUM_VC-1:0] fifo_full;
    logic [NUM_VC-1:0] fifo_push;
    logic [NUM_VC-1:0] fifo_pop;
    logic              out_ready;
    logic              out_valid;
    logic [VCW-1:0]    out_vc;
    logic              credit_in_valid;
    logic [VCW-1:0]    credit_in_vc;
    logic              credit_out_valid;
    logic [VCW-1:0]    credit_out_vc;
    logic              overflow_err;
    logic              credit_err;

    vc_buffer_scheduler #(
        .NUM_VC    (NUM_VC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CREDIT_MAX(CREDIT_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_vc           (in_vc),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_push       (fifo_push),
        .fifo_pop        (fifo_pop),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_vc          (out_vc),
        .credit_in_valid (credit_in_valid),
        .credit_in_vc    (credit_in_vc),
        .credit_out_valid(credit_out_valid),
        .credit_out_vc   (credit_out_vc),
        .overflow_err    (overflow_err),
        .credit_err      (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_VC-1:0] push;
        logic [NUM_VC-1:0] pop;
        logic              ov;
        logic [VCW-1:0]    ovc;
        logic              cov;
        logic [VCW-1:0]    covc;
        logic              oerr;
        logic              cerr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int occ  [NUM_VC];
    int cred [NUM_VC];
    int ptr;
    bit m_cov;
    int m_covc;
    bit m_ovf;
    bit m_cerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fifo_push",        32'(fifo_push),        32'(e.push));
            chk("fifo_pop",         32'(fifo_pop),         32'(e.pop));
            chk("out_valid",        32'(out_valid),        32'(e.ov));
            chk("out_vc",           32'(out_vc),           32'(e.ovc));
            chk("credit_out_valid", 32'(credit_out_valid), 32'(e.cov));
            chk("credit_out_vc",    32'(credit_out_vc),    32'(e.covc));
            chk("overflow_err",     32'(overflow_err),     32'(e.oerr));
            chk("credit_err",       32'(credit_err),       32'(e.cerr));
        end
    end

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            occ[v]  = 0;
            cred[v] = CREDIT_MAX;
        end
        ptr    = 0;
        m_cov  = 0;
        m_covc = 0;
        m_ovf  = 0;
        m_cerr = 0;
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, advance the
    // model to the state after the coming rising edge, then wait for it.
    task automatic step(input bit iv, input int ivc, input bit ordy,
                        input bit civ, input int cvc);
        exp_t e;
        int   g;
        bit   commit;
        in_valid        = iv;
        in_vc           = VCW'(ivc);
        out_ready       = ordy;
        credit_in_valid = civ;
        credit_in_vc    = VCW'(cvc);
        for (int v = 0; v < NUM_VC; v++) begin
            fifo_empty[v] = (occ[v] == 0);
            fifo_full[v]  = (occ[v] == FIFO_DEPTH);
        end

        e.push = '0;
        if (iv && ivc < NUM_VC && occ[ivc] < FIFO_DEPTH) e.push[ivc] = 1'b1;
        g = -1;
        for (int k = 0; k < NUM_VC; k++) begin
            int v;
            v = (ptr + k) % NUM_VC;
            if (g < 0 && occ[v] > 0 && cred[v] > 0 && !e.push[v]) g = v;
        end
        commit = (g >= 0) && ordy;
        e.ov   = (g >= 0);
        e.ovc  = (g >= 0) ? VCW'(g) : '0;
        e.pop  = '0;
        if (commit) e.pop[g] = 1'b1;
        e.cov  = m_cov;
        e.covc = VCW'(m_covc);
        e.oerr = m_ovf;
        e.cerr = m_cerr;
        exp_q.push_back(e);

        if (iv && e.push == '0) m_ovf = 1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (e.push[v]) occ[v]++;
            if (e.pop[v])  occ[v]--;
        end
        if (civ) begin
            if (cvc >= NUM_VC) m_cerr = 1;
            else if (!(commit && g == cvc)) begin
                if (cred[cvc] == CREDIT_MAX) m_cerr = 1;
                else cred[cvc]++;
            end
        end
        if (commit) begin
            if (!(civ && cvc == g)) cred[g]--;
            ptr = (g + 1) % NUM_VC;
        end
        m_cov = commit;
        if (commit) m_covc = g;

        @(posedge clk);
        #1;
    endtask

    // Empty all fifos and top every credit counter back up.
    task automatic drain();
        for (int n = 0; n < 48; n++) begin
            int cv;
            cv = -1;
            for (int v = NUM_VC - 1; v >= 0; v--) if (cred[v] < CREDIT_MAX) cv = v;
            step(0, 0, 1, cv >= 0, (cv >= 0) ? cv : 0);
        end
    endtask

    initial begin
        reset           = 1'b0;
        in_valid        = 1'b0;
        in_vc           = '0;
        out_ready       = 1'b0;
        credit_in_valid = 1'b0;
        credit_in_vc    = '0;
        fifo_empty      = '1;
        fifo_full       = '0;
        model_reset();
        #1;
        chk("reset credit_out_valid", 32'(credit_out_valid), 32'd0);
        chk("reset credit_out_vc",    32'(credit_out_vc),    32'd0);
        chk("reset overflow_err",     32'(overflow_err),     32'd0);
        chk("reset credit_err",       32'(credit_err),       32'd0);
        chk("reset out_valid",        32'(out_valid),        32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Single flit to VC2: grant next cycle, credit upstream one after.
        step(1, 2, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // All VCs loaded, round-robin rotation across 8 commits.
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < NUM_VC; v++) step(1, v, 0, 0, 0);
        for (int n = 0; n < 8; n++) step(0, 0, 1, 0, 0);
        drain();

        // Credit exhaustion on VC1, then resume after one returned credit.
        for (int n = 0; n < 8; n++) step(1, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(0, 0, 1, 0, 0);
        for (int n = 0; n < 4; n++) step(1, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        drain();

        // Push and non-empty on VC0 in the same cycle: no pop that cycle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        drain();

        // Overflow on full VC3, spurious credit on VC0 at CREDIT_MAX.
        for (int n = 0; n < FIFO_DEPTH; n++) step(1, 3, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        drain();

        // Asynchronous reset mid-burst with VC0 credits at 5.
        for (int n = 0; n < 6; n++) step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) step(0, 0, 1, 0, 0);
        reset      = 1'b0;
        in_valid   = 1'b0;
        fifo_empty = '1;
        fifo_full  = '0;
        #1;
        chk("async reset credit_out_valid", 32'(credit_out_valid), 32'd0);
        chk("async reset credit_out_vc",    32'(credit_out_vc),    32'd0);
        chk("async reset overflow_err",     32'(overflow_err),     32'd0);
        chk("async reset credit_err",       32'(credit_err),       32'd0);
        chk("async reset out_valid",        32'(out_valid),        32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int n = 0; n < 8; n++) step(1, 2, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(1, 0, 0, 0, 0);
        for (int n = 0; n < 12; n++) step(0, 0, 1, 0, 0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            int  cv;
            bit  civ;
            cv  = $urandom_range(NUM_VC - 1);
            civ = (cred[cv] < CREDIT_MAX && $urandom_range(1) == 1) || ($urandom_range(31) == 0);
            step($urandom_range(1) == 1, $urandom_range(NUM_VC - 1),
                 $urandom_range(3) != 0, civ, cv);
        end
        drain();

        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
